demux1x2_stream: RTL and testbench
==================================

# demux1x2_stream

Packet-aware 1-to-2 stream demultiplexer: the inverse of the team's 2:1 mux. It accepts one valid/ready stream and routes each packet to output 0 or output 1. The route is chosen by `sel` on the packet's first beat and held until the beat marked `in_last` is accepted. Each output has a one-entry registered slice, so an output can drain while input traffic is directed to the other output.

## Interface
- `WIDTH`, 8, data width of input and both outputs.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_data` input WIDTH: input beat payload.
- `in_valid` input 1: input beat present.
- `in_last` input 1: input beat is the final beat of its packet.
- `in_ready` output 1: beat accepted when `in_valid & in_ready`.
- `sel` input 1: destination (0 → out0, 1 → out1); sampled only on a packet's first beat.
- `out0_data` output WIDTH, `out0_valid` output 1, `out0_last` output 1, `out0_ready` input 1: output 0 stream.
- `out1_data` output WIDTH, `out1_valid` output 1, `out1_last` output 1, `out1_ready` input 1: output 1 stream.
- `cnt0` output 16, `cnt1` output 16: present only with `DEMUX1X2_CNT_EN` (see Configuration).

## Operation
- **Route FSM states.**
  - IDLE: no packet in flight; destination d = `sel`.
  - ROUTE0: destination forced to 0; `sel` ignored.
  - ROUTE1: destination forced to 1; `sel` ignored.
- **Transitions on an accepted beat.**
  - IDLE, `in_last`=0 → ROUTE{sel}.
  - IDLE, `in_last`=1 → IDLE (single-beat packet).
  - ROUTEx, `in_last`=1 → IDLE.
  - Otherwise the FSM holds its state.
- **Output slice x.** Registers `full_x`, `data_x`, `last_x`; `outx_valid` = `full_x`.
- **Ready.** `in_ready` = `~full_d | outd_ready`, where d is the current destination. `in_ready` combinationally depends on `sel` in IDLE and on `outd_ready`; the input side does not depend on `in_valid`.
- **Beat accepted into slice d.** `data_d` ← `in_data`, `last_d` ← `in_last`, `full_d` ← 1.
- **Drain.** When `outx_valid & outx_ready` and no new beat targets x: `full_x` ← 0.
- **Simultaneous drain and load on the same slice.** The new beat replaces the old one and `full_x` stays 1, giving full throughput of 1 beat/cycle.
- **Slice independence.** The non-destination slice drains independently; its contents are never overwritten.
- **No reordering.** Beats within a packet are never reordered or dropped; packets to different outputs may complete out of order.
- **Output stability.** While `outx_valid`=1 and `outx_ready`=0, `outx_data` and `outx_last` are stable.
- **Unused payload.** Output data/last hold their last value when not valid; they are never cleared except by reset.

## Timing
- **Reset values.** While `rst_n`=0:
  - FSM = IDLE.
  - `full_0` = `full_1` = 0, so both `outx_valid` = 0.
  - `out0_data` = `out1_data` = 0, `out0_last` = `out1_last` = 0.
  - Counters = 0.
  - `in_ready` = 1 (both slices empty).
- **Reset mid-packet.** In-flight packet state and slice contents are discarded; after release the next accepted beat is treated as a first beat.
- **Latency.** A beat accepted at edge N appears on `outd_valid` immediately after edge N: 1 cycle, registered.
- **Throughput.** 1 beat/cycle to one output when its ready is held high.
- **Back-pressure.** With the destination slice full and `outd_ready`=0, `in_ready`=0 until the slice drains.
- **First-beat blocking.** In IDLE with `sel`=1 and out1 blocked, `in_ready`=0 even if out0 is empty; there is no cross-routing.

## Configuration
- **`DEMUX1X2_CNT_EN` defined.**
  - Ports `cnt0`/`cnt1` exist.
  - Each counts packets completed on its output (`outx_valid & outx_ready & outx_last`).
  - 16-bit, wrapping 0xFFFF → 0x0000, reset to 0.
- **`DEMUX1X2_CNT_EN` undefined.** Ports and counter logic are absent; all other behaviour is identical.

## Test plan
- **Single-beat routing.** After reset: send beat 0xA5 with `last`=1, `sel`=1, both readies 1 → `out1_valid` next cycle with 0xA5, `out1_last`=1; `out0_valid` stays 0.
- **Packet lock.** Send a 4-beat packet 0x10..0x13 with `sel`=0 on beat 0, then toggle `sel` every cycle → all four beats on out0 in order, last on 0x13; FSM returns to IDLE.
- **Back-pressure and stability.** Hold `out0_ready`=0 with a 3-beat packet to out0 → beat 0 sits in out0 with stable data, `in_ready`=0. Release → beats emerge at 1/cycle with no loss or duplication.
- **Independent drain.** Fill out1 with 0x77 (`out1_ready`=0), then send packet 0x01,0x02 to out0 → out0 delivers both beats while out1 holds 0x77; then raise `out1_ready` → 0x77 drained.
- **Reset mid-packet.** Assert `rst_n`=0 after beat 2 of a 4-beat packet to out1 → outputs/valid at reset values. After release, beat 0x55 with `sel`=0 goes to out0.
- **Counter wrap (macro defined).** Complete 65,537 single-beat packets on out0 → `cnt0`=1, `cnt1`=0.

Source files
------------

// File: rtl/demux1x2_stream.sv
// demux1x2_stream: packet-aware 1-to-2 valid/ready stream demultiplexer.
// The destination is taken from sel on a packet's first beat and held until
// the beat carrying in_last is accepted. Each output owns a one-entry
// registered slice, so one output can drain while the other is loaded.
// Optional feature: define DEMUX1X2_CNT_EN to add per-output completed-packet
// counters (cnt0/cnt1, 16-bit, wrapping).
module demux1x2_stream #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  input  logic             sel,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  output logic             out0_last,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  output logic             out1_last,
  input  logic             out1_ready
`ifdef DEMUX1X2_CNT_EN
  ,
  output logic [15:0]      cnt0,
  output logic [15:0]      cnt1
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ROUTE0 = 2'b01,
    ST_ROUTE1 = 2'b10
  } state_t;

  state_t state_r;

  logic dest_s;
  logic accept_s;
  logic load0_s;
  logic load1_s;
  logic drain0_s;
  logic drain1_s;

  // Destination: live sel between packets, locked route while a packet is open.
  always_comb begin
    dest_s = 1'b0;
    case (state_r)
      ST_IDLE:   dest_s = sel;
      ST_ROUTE0: dest_s = 1'b0;
      ST_ROUTE1: dest_s = 1'b1;
      default:   dest_s = 1'b0;
    endcase
  end

  // Input ready looks only at the destination slice; no cross-routing.
  always_comb begin
    in_ready = 1'b0;
    if (dest_s) begin
      in_ready = ~out1_valid | out1_ready;
    end else begin
      in_ready = ~out0_valid | out0_ready;
    end
  end

  // Per-slice load and drain strobes derived from the handshakes.
  always_comb begin
    accept_s = in_valid & in_ready;
    load0_s  = accept_s & ~dest_s;
    load1_s  = accept_s & dest_s;
    drain0_s = out0_valid & out0_ready;
    drain1_s = out1_valid & out1_ready;
  end

  // Route FSM: opens a route on a multi-beat first beat, closes it on last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else if (accept_s) begin
      case (state_r)
        ST_IDLE: begin
          if (in_last) begin
            state_r <= ST_IDLE;
          end else if (sel) begin
            state_r <= ST_ROUTE1;
          end else begin
            state_r <= ST_ROUTE0;
          end
        end
        ST_ROUTE0: begin
          if (in_last) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_ROUTE0;
          end
        end
        ST_ROUTE1: begin
          if (in_last) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_ROUTE1;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end else begin
      state_r <= state_r;
    end
  end

  // Output slice 0: a load wins over a drain so back-to-back beats stream at full rate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0_valid <= 1'b0;
      out0_data  <= {WIDTH{1'b0}};
      out0_last  <= 1'b0;
    end else if (load0_s) begin
      out0_valid <= 1'b1;
      out0_data  <= in_data;
      out0_last  <= in_last;
    end else if (drain0_s) begin
      out0_valid <= 1'b0;
    end else begin
      out0_valid <= out0_valid;
    end
  end

  // Output slice 1: same structure as slice 0; payload holds while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out1_valid <= 1'b0;
      out1_data  <= {WIDTH{1'b0}};
      out1_last  <= 1'b0;
    end else if (load1_s) begin
      out1_valid <= 1'b1;
      out1_data  <= in_data;
      out1_last  <= in_last;
    end else if (drain1_s) begin
      out1_valid <= 1'b0;
    end else begin
      out1_valid <= out1_valid;
    end
  end

`ifdef DEMUX1X2_CNT_EN
  // Completed-packet counters: bump when a last beat leaves an output; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= 16'd0;
      cnt1 <= 16'd0;
    end else begin
      if (drain0_s && out0_last) begin
        cnt0 <= cnt0 + 16'd1;
      end else begin
        cnt0 <= cnt0;
      end
      if (drain1_s && out1_last) begin
        cnt1 <= cnt1 + 16'd1;
      end else begin
        cnt1 <= cnt1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_demux1x2_stream.sv
// Self-checking bench for demux1x2_stream: directed scenarios plus a random
// run against a queue-based packet-routing model.
module tb_demux1x2_stream;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic       sel;
  logic [7:0] out0_data;
  logic       out0_valid;
  logic       out0_last;
  logic       out0_ready;
  logic [7:0] out1_data;
  logic       out1_valid;
  logic       out1_last;
  logic       out1_ready;
`ifdef DEMUX1X2_CNT_EN
  logic [15:0] cnt0;
  logic [15:0] cnt1;
`endif

  int n_checks;
  int n_fail;

  demux1x2_stream #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .sel(sel),
    .out0_data(out0_data), .out0_valid(out0_valid), .out0_last(out0_last), .out0_ready(out0_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_last(out1_last), .out1_ready(out1_ready)
`ifdef DEMUX1X2_CNT_EN
    , .cnt0(cnt0), .cnt1(cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic l, input logic s);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    sel      = s;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic apply_reset();
    idle_in();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    idle_in();
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    rst_n = 1'b0;
    #7;
    n_checks++;
    if ({out0_valid, out1_valid} !== 2'b00) begin
      n_fail++; $display("FAIL reset_valid: got %b want 00", {out0_valid, out1_valid});
    end
    n_checks++;
    if ({out0_data, out1_data, out0_last, out1_last} !== 18'd0) begin
      n_fail++; $display("FAIL reset_payload: got %h/%h %b%b want 0", out0_data, out1_data, out0_last, out1_last);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
`ifdef DEMUX1X2_CNT_EN
    n_checks++;
    if ({cnt0, cnt1} !== 32'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %h/%h want 0", cnt0, cnt1);
    end
`endif
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_single_beat();
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    beat(8'hA5, 1'b1, 1'b1);
    cyc();
    idle_in();
    n_checks++;
    if ({out1_valid, out1_data, out1_last} !== {1'b1, 8'hA5, 1'b1}) begin
      n_fail++; $display("FAIL single_out1: got v=%b d=%h l=%b want v=1 d=a5 l=1", out1_valid, out1_data, out1_last);
    end
    n_checks++;
    if (out0_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_out0_quiet: got %b want 0", out0_valid);
    end
    cyc();
    n_checks++;
    if (out1_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_drain: got %b want 0", out1_valid);
    end
  endtask

  task automatic test_packet_lock();
    logic [7:0] d;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = 8'h10 + 8'(i);
      beat(d, (i == 3), i[0]);
      cyc();
      n_checks++;
      if ({out0_valid, out0_data, out0_last, out1_valid} !== {1'b1, d, (i == 3), 1'b0}) begin
        n_fail++; $display("FAIL lock_beat%0d: got v0=%b d0=%h l0=%b v1=%b want v0=1 d0=%h l0=%b v1=0",
                           i, out0_valid, out0_data, out0_last, out1_valid, d, (i == 3));
      end
    end
    // Route must be released: a fresh sel=1 packet lands on out1.
    beat(8'h3C, 1'b1, 1'b1);
    cyc();
    idle_in();
    n_checks++;
    if ({out1_valid, out1_data} !== {1'b1, 8'h3C}) begin
      n_fail++; $display("FAIL lock_release: got v1=%b d1=%h want v1=1 d1=3c", out1_valid, out1_data);
    end
    cyc();
  endtask

  task automatic test_backpressure();
    out0_ready = 1'b0;
    out1_ready = 1'b1;
    beat(8'h20, 1'b0, 1'b0);
    cyc();
    beat(8'h21, 1'b0, 1'b1);
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_in_ready: got %b want 0", in_ready);
    end
    cyc();
    cyc();
    n_checks++;
    if ({out0_valid, out0_data, out0_last, in_ready} !== {1'b1, 8'h20, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL bp_stable: got v=%b d=%h l=%b rdy=%b want v=1 d=20 l=0 rdy=0",
                         out0_valid, out0_data, out0_last, in_ready);
    end
    out0_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release_ready: got %b want 1", in_ready);
    end
    cyc();
    n_checks++;
    if ({out0_valid, out0_data} !== {1'b1, 8'h21}) begin
      n_fail++; $display("FAIL bp_beat1: got v=%b d=%h want v=1 d=21", out0_valid, out0_data);
    end
    beat(8'h22, 1'b1, 1'b1);
    cyc();
    idle_in();
    n_checks++;
    if ({out0_valid, out0_data, out0_last} !== {1'b1, 8'h22, 1'b1}) begin
      n_fail++; $display("FAIL bp_beat2: got v=%b d=%h l=%b want v=1 d=22 l=1", out0_valid, out0_data, out0_last);
    end
    cyc();
    n_checks++;
    if (out0_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_no_dup: got %b want 0", out0_valid);
    end
  endtask

  task automatic test_independent_drain();
    out0_ready = 1'b1;
    out1_ready = 1'b0;
    beat(8'h77, 1'b1, 1'b1);
    cyc();
    beat(8'h01, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL ind_ready0: got %b want 1", in_ready);
    end
    cyc();
    beat(8'h02, 1'b1, 1'b1);
    n_checks++;
    if ({out0_valid, out0_data, out1_valid, out1_data} !== {1'b1, 8'h01, 1'b1, 8'h77}) begin
      n_fail++; $display("FAIL ind_beat0: got %b %h %b %h want 1 01 1 77", out0_valid, out0_data, out1_valid, out1_data);
    end
    cyc();
    idle_in();
    n_checks++;
    if ({out0_valid, out0_data, out0_last, out1_valid, out1_data} !== {1'b1, 8'h02, 1'b1, 1'b1, 8'h77}) begin
      n_fail++; $display("FAIL ind_beat1: got %b %h %b %b %h want 1 02 1 1 77",
                         out0_valid, out0_data, out0_last, out1_valid, out1_data);
    end
    cyc();
    // First beat to a blocked out1 stalls even though out0 is empty.
    beat(8'h99, 1'b1, 1'b1);
    #1;
    n_checks++;
    if ({in_ready, out0_valid} !== 2'b00) begin
      n_fail++; $display("FAIL first_beat_block: got rdy=%b v0=%b want 00", in_ready, out0_valid);
    end
    idle_in();
    out1_ready = 1'b1;
    cyc();
    n_checks++;
    if ({out1_valid, out0_valid} !== 2'b00) begin
      n_fail++; $display("FAIL ind_out1_drain: got v1=%b v0=%b want 00", out1_valid, out0_valid);
    end
  endtask

  task automatic test_reset_mid_packet();
    out0_ready = 1'b1;
    out1_ready = 1'b0;
    beat(8'h30, 1'b0, 1'b1);
    cyc();
    out1_ready = 1'b1;
    beat(8'h31, 1'b0, 1'b0);
    cyc();
    idle_in();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out0_valid, out1_valid, out1_data, out1_last, in_ready} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL midrst_state: got v0=%b v1=%b d1=%h l1=%b rdy=%b want 0 0 00 0 1",
                         out0_valid, out1_valid, out1_data, out1_last, in_ready);
    end
    rst_n = 1'b1;
    cyc();
    beat(8'h55, 1'b1, 1'b0);
    cyc();
    idle_in();
    n_checks++;
    if ({out0_valid, out0_data, out1_valid} !== {1'b1, 8'h55, 1'b0}) begin
      n_fail++; $display("FAIL midrst_next: got v0=%b d0=%h v1=%b want 1 55 0", out0_valid, out0_data, out1_valid);
    end
    cyc();
  endtask

  // Random traffic against a model: one FIFO of expected beats per output,
  // each holding at most one entry, plus the packet's locked destination.
  task automatic test_random();
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic       busy;
    logic       rdest;
    logic       d;
    logic       exp_rdy;
    logic [8:0] h;
    busy  = 1'b0;
    rdest = 1'b0;
    apply_reset();
    for (int c = 0; c < 2000; c++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_data    = 8'($urandom);
      in_last    = ($urandom_range(0, 3) == 0);
      sel        = 1'($urandom);
      out0_ready = ($urandom_range(0, 3) != 0);
      out1_ready = ($urandom_range(0, 3) != 0);
      d = busy ? rdest : sel;
      exp_rdy = d ? (q1.size() == 0 || out1_ready) : (q0.size() == 0 || out0_ready);
      #1;
      n_checks++;
      if (in_ready !== exp_rdy) begin
        n_fail++; $display("FAIL rnd_in_ready c=%0d: got %b want %b", c, in_ready, exp_rdy);
      end
      if (q0.size() != 0 && out0_ready) void'(q0.pop_front());
      if (q1.size() != 0 && out1_ready) void'(q1.pop_front());
      if (in_valid && exp_rdy) begin
        if (d) q1.push_back({in_last, in_data});
        else   q0.push_back({in_last, in_data});
        if (!busy && !in_last) begin
          busy  = 1'b1;
          rdest = sel;
        end else if (busy && in_last) begin
          busy = 1'b0;
        end
      end
      cyc();
      n_checks++;
      if (out0_valid !== (q0.size() != 0)) begin
        n_fail++; $display("FAIL rnd_out0_valid c=%0d: got %b want %b", c, out0_valid, (q0.size() != 0));
      end else if (q0.size() != 0) begin
        h = q0[0];
        n_checks++;
        if ({out0_last, out0_data} !== h) begin
          n_fail++; $display("FAIL rnd_out0_beat c=%0d: got %h want %h", c, {out0_last, out0_data}, h);
        end
      end
      n_checks++;
      if (out1_valid !== (q1.size() != 0)) begin
        n_fail++; $display("FAIL rnd_out1_valid c=%0d: got %b want %b", c, out1_valid, (q1.size() != 0));
      end else if (q1.size() != 0) begin
        h = q1[0];
        n_checks++;
        if ({out1_last, out1_data} !== h) begin
          n_fail++; $display("FAIL rnd_out1_beat c=%0d: got %h want %h", c, {out1_last, out1_data}, h);
        end
      end
    end
    idle_in();
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    cyc();
  endtask

`ifdef DEMUX1X2_CNT_EN
  task automatic test_counter_wrap();
    apply_reset();
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    beat(8'h5A, 1'b1, 1'b0);
    repeat (65537) cyc();
    idle_in();
    cyc();
    n_checks++;
    if ({cnt0, cnt1} !== {16'd1, 16'd0}) begin
      n_fail++; $display("FAIL cnt_wrap: got cnt0=%h cnt1=%h want 0001 0000", cnt0, cnt1);
    end
  endtask
`endif

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    in_data    = 8'h00;
    in_valid   = 1'b0;
    in_last    = 1'b0;
    sel        = 1'b0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    test_reset();
    test_single_beat();
    test_packet_lock();
    test_backpressure();
    test_independent_drain();
    test_reset_mid_packet();
    test_random();
`ifdef DEMUX1X2_CNT_EN
    test_counter_wrap();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
